uart_tx: RTL and testbench

Serial transmitter for the UART link. It accepts one parallel data word per handshake and shifts it out on a single line as a frame: start bit, data LSB-first, optional even/odd parity, stop bit. It sits between the register/FIFO logic that supplies bytes and the pad driving the serial line. It runs at one bit per clock; the clock is the baud-rate (bit) clock, and any baud division is done upstream.

---
 rtl/uart_tx_pkg.sv | 6 +
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx_parity.sv | 12 +
 rtl/uart_tx.sv | 97 +++++++++
 tb/tb_uart_tx.sv | 121 ++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state encoding and parity-type constants shared by the UART transmitter.
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel request side and serial/busy outputs of the UART transmitter.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;
    modport master (output P_DATA, Data_valid, PAR_EN, PAR_TYP, input TX_OUT, busy);
    modport slave  (input P_DATA, Data_valid, PAR_EN, PAR_TYP, output TX_OUT, busy);
endinterface

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: reduction-XOR parity of a word, inverted for odd parity.
module uart_tx_parity
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  typ_i,
    output logic                  par_o
);
    assign par_o = (typ_i == ODD) ? ~(^data_i) : ^data_i;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: one-bit-per-clock UART frame transmitter (start, data LSB-first, optional parity, stop).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input logic   CLK,
    input logic   RST,
    uart_tx_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_n;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pen_q, pen_d, ptyp_q, ptyp_d;
    logic                  tx_q, tx_d, busy_q, busy_d;
    logic                  par;

    uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data_i(data_q),
        .typ_i (ptyp_q),
        .par_o (par)
    );

    assign cnt_n = cnt_q + 1'b1;

    // Outputs are computed from the next state so the registered line lines up with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        case (state_q)
            IDLE: begin
                busy_d = bus.Data_valid;
                tx_d   = ~bus.Data_valid;
                if (bus.Data_valid) begin
                    state_d = START;
                    data_d  = bus.P_DATA;
                    pen_d   = bus.PAR_EN;
                    ptyp_d  = bus.PAR_TYP;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = data_q[0];
            end
            DATA: begin
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = pen_q ? PARITY : STOP;
                    cnt_d   = '0;
                    tx_d    = pen_q ? par : 1'b1;
                end else begin
                    cnt_d = cnt_n;
                    tx_d  = data_q[cnt_n];
                end
            end
            PARITY: state_d = STOP;
            STOP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks of uart_tx with hand-built expected bit sequences.
module tb_uart_tx;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();
    uart_tx #(.DATA_WIDTH(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // bits[k] is the expected line level in the k-th frame cycle; inj pulses a 0xFF request at edge E+inj.
    task automatic send(input string tag, input logic [7:0] d, input logic pen, input logic typ,
                        input logic [10:0] bits, input int len, input int inj, input int idle_n);
        @(negedge CLK);
        bus.P_DATA = d;
        bus.PAR_EN = pen;
        bus.PAR_TYP = typ;
        bus.Data_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.Data_valid = 1'b0;
        bus.P_DATA = ~d;
        bus.PAR_EN = ~pen;
        bus.PAR_TYP = ~typ;
        check({tag, "_start_tx"}, bus.TX_OUT, bits[0]);
        check({tag, "_start_busy"}, bus.busy, 1'b1);
        for (int k = 1; k <= len; k++) begin
            if (k == inj) begin
                @(negedge CLK);
                bus.P_DATA = 8'hFF;
                bus.Data_valid = 1'b1;
                @(posedge CLK);
                #1;
                bus.Data_valid = 1'b0;
            end else begin
                @(posedge CLK);
                #1;
            end
            check($sformatf("%s_tx%0d", tag, k), bus.TX_OUT, k < len ? bits[k] : 1'b1);
            check($sformatf("%s_busy%0d", tag, k), bus.busy, k < len);
        end
        for (int k = 0; k < idle_n; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("%s_idle_tx%0d", tag, k), bus.TX_OUT, 1'b1);
            check($sformatf("%s_idle_busy%0d", tag, k), bus.busy, 1'b0);
        end
    endtask

    initial begin
        bus.P_DATA = 8'h00;
        bus.Data_valid = 1'b0;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_tx", bus.TX_OUT, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("idle_tx", bus.TX_OUT, 1'b1);
        check("idle_busy", bus.busy, 1'b0);

        send("f00", 8'h00, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00, 1'b0}, 10, 0, 2);
        send("a5e", 8'hA5, 1'b1, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0, 1);
        send("a5o", 8'hA5, 1'b1, 1'b1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 0, 1);
        send("01e", 8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h01, 1'b0}, 11, 0, 1);
        send("ign", 8'h00, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00, 1'b0}, 10, 4, 3);
        send("stp", 8'hA5, 1'b1, 1'b1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 11, 3);
        send("3co", 8'h3C, 1'b1, 1'b1, {1'b1, 1'b1, 8'h3C, 1'b0}, 11, 0, 0);
        send("c3n", 8'hC3, 1'b0, 1'b0, {1'b0, 1'b1, 8'hC3, 1'b0}, 10, 0, 1);

        @(negedge CLK);
        bus.P_DATA = 8'h00;
        bus.PAR_EN = 1'b0;
        bus.Data_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.Data_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("abort_pre_tx", bus.TX_OUT, 1'b0);
        check("abort_pre_busy", bus.busy, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        check("abort_tx", bus.TX_OUT, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("post_rst_tx%0d", k), bus.TX_OUT, 1'b1);
            check($sformatf("post_rst_busy%0d", k), bus.busy, 1'b0);
        end
        send("rec", 8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h01, 1'b0}, 11, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
